// File: rtl/mem_word_transfer_ctrl.sv
// Moore sequencer moving a 32-bit word between byte-wide memory and a register
// file entry, big-endian, one byte per cycle with AR post-increment.
module mem_word_transfer_ctrl #(
    parameter logic [2:0] RF_LOAD     = 3'b010,
    parameter logic [4:0] ALU_PASS_A  = 5'b00000,
    parameter logic [1:0] ARF_INC     = 2'b01,
    parameter logic [2:0] ARF_AR_SEL  = 3'b010,
    parameter logic [1:0] ARF_OUTD_AR = 2'b10,
    parameter logic [1:0] DR_LOAD     = 2'b01,
    parameter logic [1:0] DR_SHL_LOAD = 2'b10
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Req,
    input  logic       Op,
    input  logic [1:0] RegIdx,
    output logic       Busy,
    output logic       Done,
    output logic [2:0] RF_OutASel,
    output logic [2:0] RF_FunSel,
    output logic [3:0] RF_RegSel,
    output logic [4:0] ALU_FunSel,
    output logic       ALU_WF,
    output logic [1:0] ARF_OutDSel,
    output logic [1:0] ARF_FunSel,
    output logic [2:0] ARF_RegSel,
    output logic       Mem_WR,
    output logic       Mem_CS,
    output logic [1:0] MuxASel,
    output logic [1:0] MuxCSel,
    output logic       DR_E,
    output logic [1:0] DR_FunSel
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LD_RD = 3'd1,
        LD_WB = 3'd2,
        ST_WR = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state_reg, state_next;
    logic [1:0] cnt_reg, cnt_next;
    logic       op_reg, op_next;
    logic [1:0] idx_reg, idx_next;
    logic [3:0] wb_onehot;

    // R1 maps to the MSB of RF_RegSel, R4 to the LSB.
    for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
        assign wb_onehot[gi] = (idx_reg == 2'(3 - gi));
    end

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            op_reg    <= 1'b0;
            idx_reg   <= 2'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (Req) begin
                    op_next    = Op;
                    idx_next   = RegIdx;
                    cnt_next   = 2'd0;
                    state_next = Op ? ST_WR : LD_RD;
                end
            end
            LD_RD: begin
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) state_next = LD_WB;
            end
            LD_WB: state_next = DONE;
            ST_WR: begin
                cnt_next = cnt_reg + 2'd1;
                if (cnt_reg == 2'd3) state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        Busy        = (state_reg != IDLE);
        Done        = 1'b0;
        RF_OutASel  = 3'b000;
        RF_FunSel   = 3'b000;
        RF_RegSel   = 4'b0000;
        ALU_FunSel  = 5'b00000;
        ALU_WF      = 1'b0;
        ARF_OutDSel = 2'b00;
        ARF_FunSel  = 2'b00;
        ARF_RegSel  = 3'b000;
        Mem_WR      = 1'b0;
        Mem_CS      = 1'b1;
        MuxASel     = 2'b00;
        MuxCSel     = 2'b00;
        DR_E        = 1'b0;
        DR_FunSel   = 2'b00;
        case (state_reg)
            LD_RD: begin
                Mem_CS      = 1'b0;
                ARF_OutDSel = ARF_OUTD_AR;
                ARF_RegSel  = ARF_AR_SEL;
                ARF_FunSel  = ARF_INC;
                DR_E        = 1'b1;
                DR_FunSel   = (cnt_reg == 2'd0) ? DR_LOAD : DR_SHL_LOAD;
            end
            LD_WB: begin
                MuxASel   = 2'b10;
                RF_FunSel = RF_LOAD;
                RF_RegSel = wb_onehot;
            end
            ST_WR: begin
                RF_OutASel  = {1'b0, idx_reg};
                ALU_FunSel  = ALU_PASS_A;
                MuxCSel     = 2'd3 - cnt_reg;
                Mem_CS      = 1'b0;
                Mem_WR      = 1'b1;
                ARF_OutDSel = ARF_OUTD_AR;
                ARF_RegSel  = ARF_AR_SEL;
                ARF_FunSel  = ARF_INC;
            end
            DONE:    Done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_word_transfer_ctrl.sv
// Bench for mem_word_transfer_ctrl: per-cycle output vectors plus a small
// behavioural datapath (memory, AR, DR, RF) driven by the controller outputs.
module tb_mem_word_transfer_ctrl;

    logic       Clock = 1'b0;
    logic       Reset, Req, Op;
    logic [1:0] RegIdx;
    logic       Busy, Done, ALU_WF, Mem_WR, Mem_CS, DR_E;
    logic [2:0] RF_OutASel, RF_FunSel, ARF_RegSel;
    logic [3:0] RF_RegSel;
    logic [4:0] ALU_FunSel;
    logic [1:0] ARF_OutDSel, ARF_FunSel, MuxASel, MuxCSel, DR_FunSel;

    always #5 Clock = ~Clock;

    mem_word_transfer_ctrl dut (
        .Clock(Clock), .Reset(Reset), .Req(Req), .Op(Op), .RegIdx(RegIdx),
        .Busy(Busy), .Done(Done),
        .RF_OutASel(RF_OutASel), .RF_FunSel(RF_FunSel), .RF_RegSel(RF_RegSel),
        .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
        .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel), .ARF_RegSel(ARF_RegSel),
        .Mem_WR(Mem_WR), .Mem_CS(Mem_CS), .MuxASel(MuxASel), .MuxCSel(MuxCSel),
        .DR_E(DR_E), .DR_FunSel(DR_FunSel)
    );

    typedef struct packed {
        logic       busy;
        logic       done;
        logic [2:0] rf_outasel;
        logic [2:0] rf_funsel;
        logic [3:0] rf_regsel;
        logic [4:0] alu_funsel;
        logic       alu_wf;
        logic [1:0] arf_outdsel;
        logic [1:0] arf_funsel;
        logic [2:0] arf_regsel;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] muxasel;
        logic [1:0] muxcsel;
        logic       dr_e;
        logic [1:0] dr_funsel;
    } out_t;

    typedef struct {
        logic       rst_n;
        logic       req;
        logic       op;
        logic [1:0] idx;
        out_t       exp;
    } vec_t;

    vec_t tbl [0:14];
    int   checks = 0;
    int   errors = 0;

    // Behavioural datapath
    logic [7:0]  mem [0:65535];
    logic [15:0] ar;
    logic [31:0] dr;
    logic [31:0] rf [0:3];
    logic        wf_seen = 1'b0;
    logic        poke_ar_en, poke_mem_en, poke_rf_en;
    logic [15:0] poke_ar_val, poke_mem_addr;
    logic [31:0] poke_mem_word, poke_rf_val;
    logic [1:0]  poke_rf_idx;

    logic [15:0] mem_addr;
    logic [31:0] alu_out;
    logic [7:0]  muxc_byte;
    assign mem_addr  = (ARF_OutDSel == 2'b10) ? ar : 16'h0000;
    assign alu_out   = (ALU_FunSel == 5'b00000) ? rf[RF_OutASel[1:0]] : 32'h0;
    assign muxc_byte = alu_out[8*MuxCSel +: 8];

    always @(posedge Clock) begin
        if (ALU_WF) wf_seen <= 1'b1;
        if (!Mem_CS && Mem_WR) mem[mem_addr] <= muxc_byte;
        if (!Mem_CS && !Mem_WR && DR_E) begin
            if (DR_FunSel == 2'b01)      dr <= {24'h0, mem[mem_addr]};
            else if (DR_FunSel == 2'b10) dr <= {dr[23:0], mem[mem_addr]};
        end
        if (ARF_RegSel[1] && ARF_FunSel == 2'b01) ar <= ar + 16'd1;
        if (RF_FunSel == 3'b010)
            for (int k = 0; k < 4; k++)
                if (RF_RegSel[3-k]) rf[k] <= (MuxASel == 2'b10) ? dr : 32'h0;
        if (poke_ar_en) ar <= poke_ar_val;
        if (poke_mem_en)
            for (int b = 0; b < 4; b++)
                mem[poke_mem_addr + 16'(b)] <= poke_mem_word[31-8*b -: 8];
        if (poke_rf_en) rf[poke_rf_idx] <= poke_rf_val;
    end

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {mem[a], mem[a+16'd1], mem[a+16'd2], mem[a+16'd3]};
    endfunction

    function automatic out_t sample_out();
        out_t o;
        o.busy = Busy; o.done = Done; o.rf_outasel = RF_OutASel; o.rf_funsel = RF_FunSel;
        o.rf_regsel = RF_RegSel; o.alu_funsel = ALU_FunSel; o.alu_wf = ALU_WF;
        o.arf_outdsel = ARF_OutDSel; o.arf_funsel = ARF_FunSel; o.arf_regsel = ARF_RegSel;
        o.mem_wr = Mem_WR; o.mem_cs = Mem_CS; o.muxasel = MuxASel; o.muxcsel = MuxCSel;
        o.dr_e = DR_E; o.dr_funsel = DR_FunSel;
        return o;
    endfunction

    function automatic out_t e_idle();
        out_t o = '0;
        o.mem_cs = 1'b1;
        return o;
    endfunction

    function automatic out_t e_ld(input logic first);
        out_t o = e_idle();
        o.busy = 1'b1; o.mem_cs = 1'b0; o.arf_outdsel = 2'b10; o.arf_funsel = 2'b01;
        o.arf_regsel = 3'b010; o.dr_e = 1'b1; o.dr_funsel = first ? 2'b01 : 2'b10;
        return o;
    endfunction

    function automatic out_t e_wb(input logic [3:0] rs);
        out_t o = e_idle();
        o.busy = 1'b1; o.muxasel = 2'b10; o.rf_funsel = 3'b010; o.rf_regsel = rs;
        return o;
    endfunction

    function automatic out_t e_st(input logic [2:0] asel, input logic [1:0] csel);
        out_t o = e_idle();
        o.busy = 1'b1; o.rf_outasel = asel; o.muxcsel = csel; o.mem_cs = 1'b0; o.mem_wr = 1'b1;
        o.arf_outdsel = 2'b10; o.arf_funsel = 2'b01; o.arf_regsel = 3'b010;
        return o;
    endfunction

    function automatic out_t e_done();
        out_t o = e_idle();
        o.busy = 1'b1; o.done = 1'b1;
        return o;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    task automatic set_ar(input logic [15:0] v);
        poke_ar_en = 1'b1; poke_ar_val = v;
        cyc();
        poke_ar_en = 1'b0;
    endtask

    task automatic set_mem(input logic [15:0] a, input logic [31:0] w);
        poke_mem_en = 1'b1; poke_mem_addr = a; poke_mem_word = w;
        cyc();
        poke_mem_en = 1'b0;
    endtask

    task automatic set_rf(input logic [1:0] i, input logic [31:0] v);
        poke_rf_en = 1'b1; poke_rf_idx = i; poke_rf_val = v;
        cyc();
        poke_rf_en = 1'b0;
    endtask

    // Counts edges until Done is seen; gives up after a fixed budget.
    task automatic wait_done(output int n);
        n = 1;
        while (!Done && n < 20) begin
            cyc();
            n++;
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            Reset = tbl[i].rst_n; Req = tbl[i].req; Op = tbl[i].op; RegIdx = tbl[i].idx;
            cyc();
            chk($sformatf("vec%0d", i), 64'(sample_out()), 64'(tbl[i].exp));
            $display("vec %0d: rst_n=%b req=%b op=%b idx=%0d -> outputs %h", i,
                     tbl[i].rst_n, tbl[i].req, tbl[i].op, tbl[i].idx, sample_out());
        end
    endtask

    initial begin
        int n;
        Reset = 1'b0; Req = 1'b0; Op = 1'b0; RegIdx = 2'd0;
        poke_ar_en = 1'b0; poke_mem_en = 1'b0; poke_rf_en = 1'b0;
        poke_ar_val = '0; poke_mem_addr = '0; poke_mem_word = '0;
        poke_rf_idx = '0; poke_rf_val = '0;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, e_idle()};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, e_idle()};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 2'd1, e_ld(1'b1)};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 2'd0, e_ld(1'b0)};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 2'd0, e_ld(1'b0)};
        tbl[5]  = '{1'b1, 1'b0, 1'b0, 2'd0, e_ld(1'b0)};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 2'd0, e_wb(4'b0100)};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 2'd0, e_done()};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, e_idle()};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 2'd2, e_st(3'b010, 2'd3)};
        tbl[10] = '{1'b1, 1'b0, 1'b0, 2'd0, e_st(3'b010, 2'd2)};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 2'd0, e_st(3'b010, 2'd1)};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 2'd0, e_st(3'b010, 2'd0)};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 2'd0, e_done()};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 2'd0, e_idle()};

        @(negedge Clock);
        // LOAD R2 from 0x0040
        set_ar(16'h0040);
        set_mem(16'h0040, 32'h12345678);
        set_rf(2'd2, 32'hA1B2C3D4);
        run_vecs(0, 8);
        chk("load_r2", rf[1], 32'h12345678);
        chk("load_ar", 64'(ar), 64'h0044);
        $display("load R2: R2=%h AR=%h", rf[1], ar);

        // STORE R3 to 0x0080
        set_ar(16'h0080);
        run_vecs(9, 14);
        chk("store_mem", mem_word(16'h0080), 32'hA1B2C3D4);
        chk("store_ar", 64'(ar), 64'h0084);
        chk("store_r3", rf[2], 32'hA1B2C3D4);
        $display("store R3: mem[80]=%h AR=%h", mem_word(16'h0080), ar);

        // Req pulses and RegIdx changes while busy are ignored
        set_ar(16'h0020);
        set_mem(16'h0020, 32'hCAFEBABE);
        set_rf(2'd0, 32'h11111111);
        set_rf(2'd3, 32'h00000000);
        Req = 1'b1; Op = 1'b0; RegIdx = 2'd3;
        cyc();
        chk("pulse_accept", 64'(Busy), 64'd1);
        for (int c = 1; c <= 5; c++) begin
            Req = c[0]; Op = 1'b1; RegIdx = 2'd0;
            cyc();
            chk($sformatf("pulse_done_c%0d", c), 64'(Done), 64'(c == 5));
        end
        Req = 1'b0;
        cyc();
        chk("pulse_idle", 64'(Busy), 64'd0);
        cyc();
        cyc();
        chk("pulse_no_requeue", 64'(Busy), 64'd0);
        chk("pulse_r4", rf[3], 32'hCAFEBABE);
        chk("pulse_r1_kept", rf[0], 32'h11111111);
        chk("pulse_ar", 64'(ar), 64'h0024);
        $display("pulsed load R4: R4=%h R1=%h AR=%h", rf[3], rf[0], ar);

        // Reset at the edge ending the third LD_RD cycle
        set_ar(16'h0030);
        set_mem(16'h0030, 32'h01020304);
        set_rf(2'd2, 32'h55AA55AA);
        Req = 1'b1; Op = 1'b0; RegIdx = 2'd2;
        cyc();
        Req = 1'b0;
        cyc();
        cyc();
        Reset = 1'b0;
        cyc();
        chk("abort_outputs", 64'(sample_out()), 64'(e_idle()));
        Reset = 1'b1;
        cyc();
        cyc();
        chk("abort_stays_idle", 64'(Busy), 64'd0);
        chk("abort_r3_kept", rf[2], 32'h55AA55AA);
        chk("abort_ar", 64'(ar), 64'h0033);
        $display("aborted load R3: R3=%h AR=%h", rf[2], ar);

        // Req held: LOAD R1 then STORE R1 across AR wrap
        set_ar(16'hFFFE);
        set_mem(16'hFFFE, 32'h9ABCDEF0);
        set_rf(2'd0, 32'h00000000);
        Req = 1'b1; Op = 1'b0; RegIdx = 2'd0;
        cyc();
        wait_done(n);
        chk("held_load_cycles", 64'(n), 64'd6);
        Op = 1'b1;
        cyc();
        chk("held_gap_idle", 64'(Busy), 64'd0);
        chk("held_ar_wrap", 64'(ar), 64'h0002);
        cyc();
        chk("held_store_accept", 64'(sample_out()), 64'(e_st(3'b000, 2'd3)));
        Req = 1'b0;
        wait_done(n);
        chk("held_store_cycles", 64'(n), 64'd5);
        cyc();
        chk("held_r1", rf[0], 32'h9ABCDEF0);
        chk("held_mem", mem_word(16'h0002), 32'h9ABCDEF0);
        chk("held_ar", 64'(ar), 64'h0006);
        $display("held req: R1=%h mem[2]=%h AR=%h", rf[0], mem_word(16'h0002), ar);

        // LOAD R4 of 0x000000FF over a stale DR
        set_ar(16'h0010);
        set_mem(16'h0010, 32'h000000FF);
        set_rf(2'd3, 32'hDEADBEEF);
        Req = 1'b1; Op = 1'b0; RegIdx = 2'd3;
        cyc();
        Req = 1'b0;
        wait_done(n);
        chk("clear_load_cycles", 64'(n), 64'd6);
        cyc();
        chk("clear_r4", rf[3], 32'h000000FF);
        chk("clear_ar", 64'(ar), 64'h0014);
        $display("load R4: R4=%h AR=%h", rf[3], ar);

        chk("alu_wf_never", 64'(wf_seen), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
